// File: rtl/alu1.sv
// Single-cycle registered ALU: add/sub, logic ops, shifts and signed set-less-than.
// Define ALU1_FLAGS_EN to build the zero/negative/carry/overflow flag registers; otherwise the flags read 0.
module alu1 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] ALU_Result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRA = 3'b110,
    OP_SLT = 3'b111
  } op_e;

  op_e              op;
  logic [SHW-1:0]   shamt;
  logic             is_sub;
  logic [WIDTH-1:0] b_operand;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] result_reg;

  assign op    = op_e'(opcode);
  assign shamt = B[SHW-1:0];

  // Subtraction shares the adder as A + ~B + 1.
  assign is_sub    = (op == OP_SUB);
  assign b_operand = is_sub ? ~B : B;

`ifdef ALU1_FLAGS_EN
  logic [WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, A} + {1'b0, b_operand} + {{WIDTH{1'b0}}, is_sub};
  assign sum     = sum_ext[WIDTH-1:0];
`else
  assign sum = A + b_operand + {{(WIDTH-1){1'b0}}, is_sub};
`endif

  always_comb begin
    result_next = '0;
    case (op)
      OP_ADD,
      OP_SUB: result_next = sum;
      OP_AND: result_next = A & B;
      OP_OR:  result_next = A | B;
      OP_XOR: result_next = A ^ B;
      OP_SLL: result_next = A << shamt;
      OP_SRA: result_next = $unsigned($signed(A) >>> shamt);
      OP_SLT: result_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: result_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign ALU_Result = result_reg;

`ifdef ALU1_FLAGS_EN
  logic carry_next;
  logic overflow_next;
  logic zero_reg;
  logic negative_reg;
  logic carry_reg;
  logic overflow_reg;

  // Overflow when both adder inputs share a sign that the sum does not.
  always_comb begin
    carry_next    = 1'b0;
    overflow_next = 1'b0;
    if (op == OP_ADD || op == OP_SUB) begin
      carry_next    = sum_ext[WIDTH];
      overflow_next = (A[WIDTH-1] == b_operand[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_reg     <= 1'b1;
      negative_reg <= 1'b0;
      carry_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      zero_reg     <= (result_next == '0);
      negative_reg <= result_next[WIDTH-1];
      carry_reg    <= carry_next;
      overflow_reg <= overflow_next;
    end
  end

  assign zero     = zero_reg;
  assign negative = negative_reg;
  assign carry    = carry_reg;
  assign overflow = overflow_reg;
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu1.sv
// Scoreboard testbench for alu1 (WIDTH=32); flag expectations follow whether ALU1_FLAGS_EN is defined.
module tb_alu1;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opcode;
  logic [W-1:0] alu_result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    string        tag;
  } exp_t;

  exp_t sb[$];

  alu1 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .A(a),
    .B(b),
    .opcode(opcode),
    .ALU_Result(alu_result),
    .zero(zero),
    .negative(negative),
    .carry(carry),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mask_flags(input exp_t e);
    exp_t m;
    m = e;
`ifndef ALU1_FLAGS_EN
    m.z = 1'b0;
    m.n = 1'b0;
    m.c = 1'b0;
    m.v = 1'b0;
`endif
    return m;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] res, input logic z, input logic n,
                              input logic c, input logic v, input string tag);
    exp_t e;
    e.res = res; e.z = z; e.n = n; e.c = c; e.v = v; e.tag = tag;
    return e;
  endfunction

  // Reference behaviour written from the opcode table, using a 33-bit sum.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [2:0] op, input string tag);
    exp_t e;
    logic [W:0] s;
    e = mk('0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    case (op)
      3'd0: begin
        s = {1'b0, av} + {1'b0, bv};
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (av[W-1] == bv[W-1]) && (e.res[W-1] != av[W-1]);
      end
      3'd1: begin
        s = {1'b0, av} + {1'b0, ~bv} + 33'd1;
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (av[W-1] != bv[W-1]) && (e.res[W-1] != av[W-1]);
      end
      3'd2: e.res = av & bv;
      3'd3: e.res = av | bv;
      3'd4: e.res = av ^ bv;
      3'd5: e.res = av << bv[4:0];
      3'd6: e.res = $unsigned($signed(av) >>> bv[4:0]);
      default: e.res = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2:0] op, input exp_t e);
    a = av;
    b = bv;
    opcode = op;
    sb.push_back(mask_flags(e));
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: output observed with no expected entry");
      return;
    end
    e = sb.pop_front();
    total += 5;
    if (alu_result !== e.res) begin
      bad++;
      $display("FAIL %s result: got %h want %h", e.tag, alu_result, e.res);
    end
    if (zero !== e.z) begin
      bad++;
      $display("FAIL %s zero: got %b want %b", e.tag, zero, e.z);
    end
    if (negative !== e.n) begin
      bad++;
      $display("FAIL %s negative: got %b want %b", e.tag, negative, e.n);
    end
    if (carry !== e.c) begin
      bad++;
      $display("FAIL %s carry: got %b want %b", e.tag, carry, e.c);
    end
    if (overflow !== e.v) begin
      bad++;
      $display("FAIL %s overflow: got %b want %b", e.tag, overflow, e.v);
    end
    $display("txn %s A=%h B=%h res=%h z%b n%b c%b v%b", e.tag, a, b, alu_result,
             zero, negative, carry, overflow);
  endtask

  task automatic one_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] op, input exp_t e);
    issue(av, bv, op, e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_reset_state(input string tag);
    logic exp_z;
`ifdef ALU1_FLAGS_EN
    exp_z = 1'b1;
`else
    exp_z = 1'b0;
`endif
    total += 5;
    if (alu_result !== '0) begin bad++; $display("FAIL %s result: got %h want 0", tag, alu_result); end
    if (zero !== exp_z) begin bad++; $display("FAIL %s zero: got %b want %b", tag, zero, exp_z); end
    if (negative !== 1'b0) begin bad++; $display("FAIL %s negative: got %b want 0", tag, negative); end
    if (carry !== 1'b0) begin bad++; $display("FAIL %s carry: got %b want 0", tag, carry); end
    if (overflow !== 1'b0) begin bad++; $display("FAIL %s overflow: got %b want 0", tag, overflow); end
    $display("txn %s res=%h z%b n%b c%b v%b", tag, alu_result, zero, negative, carry, overflow);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a = 32'h1234_5678;
    b = 32'h0000_0001;
    opcode = 3'd0;
    #2;
    check_reset_state("reset_no_clk");
    @(posedge clk);
    #1;
    check_reset_state("reset_held_edge");
    @(negedge clk);
    rst = 1'b0;
    one_op(32'd7, 32'd9, 3'd0, model(32'd7, 32'd9, 3'd0, "first_after_reset"));
  endtask

  task automatic test_logic();
    logic [W-1:0] av = 32'h1234_5678;
    logic [W-1:0] bv = 32'hAABB_CCDD;
    one_op(av, bv, 3'b010, mk(32'h0230_4458, 1'b0, 1'b0, 1'b0, 1'b0, "and"));
    one_op(av, bv, 3'b011, mk(32'hBABF_DEFD, 1'b0, 1'b1, 1'b0, 1'b0, "or"));
    one_op(av, bv, 3'b100, mk(32'hB88F_9AA5, 1'b0, 1'b1, 1'b0, 1'b0, "xor"));
  endtask

  task automatic test_arith();
    logic [W-1:0] av = 32'h1234_5678;
    logic [W-1:0] bv = 32'hAABB_CCDD;
    one_op(av, bv, 3'b000, mk(32'hBCF0_2355, 1'b0, 1'b1, 1'b0, 1'b0, "add"));
    one_op(av, bv, 3'b001, mk(32'h6778_899B, 1'b0, 1'b0, 1'b0, 1'b0, "sub"));
  endtask

  task automatic test_shift_slt();
    logic [W-1:0] av = 32'h1234_5678;
    logic [W-1:0] bv = 32'hAABB_CCDD;
    one_op(av, bv, 3'b101, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, "sll29"));
    one_op(av, bv, 3'b111, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, "slt_pos_neg"));
    one_op(bv, av, 3'b111, mk(32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, "slt_neg_pos"));
    one_op(32'h8000_0000, 32'd4, 3'b110, mk(32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0, "sra4"));
    one_op(32'hDEAD_BEEF, 32'hFFFF_FFE0, 3'b101, mk(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, "sll_shamt0"));
    one_op(32'h8000_0001, 32'd31, 3'b110, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, "sra31"));
  endtask

  task automatic test_boundaries();
    one_op(32'h7FFF_FFFF, 32'd1, 3'b000, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, "add_ovf"));
    one_op(32'hFFFF_FFFF, 32'd1, 3'b000, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, "add_carry"));
    one_op(32'd5, 32'd5, 3'b001, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, "sub_equal"));
    one_op(32'h8000_0000, 32'd1, 3'b001, mk(32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1, "sub_ovf"));
  endtask

  task automatic test_midstream_reset();
    one_op(32'd1, 32'd2, 3'b000, mk(32'd3, 1'b0, 1'b0, 1'b0, 1'b0, "pre_reset"));
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("reset_async");
    a = 32'hFFFF_FFFF;
    b = 32'd1;
    opcode = 3'd0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_reset_state("reset_hold");
    end
    #3;
    rst = 1'b0;
    one_op(32'd10, 32'd3, 3'b001, mk(32'd7, 1'b0, 1'b0, 1'b1, 1'b0, "post_reset"));
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] av = 32'hF000_1234;
    logic [W-1:0] bv = 32'h0F0F_0F03;
    issue(av, bv, 3'd0, model(av, bv, 3'd0, "b2b_op0"));
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      check_out();
      if (i < 8) issue(av, bv, 3'(i), model(av, bv, 3'(i), $sformatf("b2b_op%0d", i)));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [2:0]   op;
    av = $urandom; bv = $urandom; op = 3'($urandom_range(0, 7));
    issue(av, bv, op, model(av, bv, op, "rand0"));
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk);
      #1;
      check_out();
      if (i < 24) begin
        av = $urandom; bv = $urandom; op = 3'($urandom_range(0, 7));
        if (i % 5 == 0) bv = av;
        issue(av, bv, op, model(av, bv, op, $sformatf("rand%0d", i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_arith();
    test_shift_slt();
    test_boundaries();
    test_midstream_reset();
    test_back_to_back();
    test_random();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
